waypoint_navigator: RTL and testbench
=====================================

// Module: waypoint_navigator
// PURPOSE
//  Downstream consumer of the rotary-encoder position tracker. Accepts a target (x,y) in dm and
//  compares it with the tracked position (cur_x/cur_y). Drives the motors Y-axis first, then
//  X-axis, making 90-degree turns in place as needed.
//  Owns the orientation register: ori and turning feed back into the encoder stage.
// PARAMETERS
//  COORD_W      33    width of target and position coordinates (unsigned dm)
//  TURN_CYCLES  5000  clk cycles for one in-place 90-degree turn (>=2)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous, active-high reset
//  tgt_valid  in   1        target offered
//  tgt_ready  out  1        navigator idle and able to accept a target
//  tgt_x      in   COORD_W  target x, sampled on the accept cycle
//  tgt_y      in   COORD_W  target y, sampled on the accept cycle
//  cur_x      in   COORD_W  tracked x from the encoder stage
//  cur_y      in   COORD_W  tracked y from the encoder stage
//  ori        out  2        heading: 00=+Y, 01=+X, 10=-X, 11=-Y
//  turning    out  1        high while a turn is executing (freezes encoder counting)
//  motor_l    out  2        left motor: 00=stop, 01=fwd, 10=rev
//  motor_r    out  2        right motor, same encoding
//  busy       out  1        high in every state except IDLE
//  arrived    out  1        one-cycle pulse when the target is reached
// BEHAVIOUR
//  Reset: state=IDLE, ori=00, turning=0, motor_l=motor_r=00, arrived=0, busy=0.
//  All outputs are registered except tgt_ready, which is (state==IDLE && !rst).
//  Accept: tgt_valid && tgt_ready latches tgt_x/tgt_y and moves IDLE->ALIGN on the next edge.
//    While busy, tgt_valid is ignored; there is no target queue.
//  ALIGN (1 cycle):
//    - cur_y != tgt_y: desired heading is 00 if tgt_y > cur_y, else 11.
//    - else cur_x != tgt_x: desired heading is 01 if tgt_x > cur_x, else 10.
//    - else -> DONE.
//    - desired == ori -> DRIVE; otherwise -> TURN.
//  TURN: turning=1. CW step (00->01->11->10->00): motor_l=01, motor_r=10. CCW step: reversed.
//    CW is used when desired is one CW step away, or two steps (180 degrees); CCW otherwise.
//    Counter runs TURN_CYCLES cycles. On the last cycle ori advances one step and turning
//    drops, then state -> ALIGN. A 180-degree turn is therefore two TURN passes.
//  DRIVE: motor_l=motor_r=01, turning=0. Each cycle the active-axis coordinate is checked
//    against the target.
//    - Equal -> motors 00, state -> ALIGN.
//    - Already past the target (overshoot) -> ALIGN, which turns back.
//  DONE: arrived=1 for exactly one cycle, motors 00, then -> IDLE. A target equal to the
//    current position gives ACCEPT->ALIGN->DONE with arrived 2 cycles after accept.
//  Arithmetic: unsigned magnitude compares only, no subtraction; no wrap handling required.
//  Reset mid-turn: ori keeps its reset value 00 regardless of progress; the counter clears.
// CONFIGURATION
//  NAV_ABORT_EN defined: adds input port abort (1 bit).
//    - abort=1 in any busy state -> next cycle state=IDLE, motors 00, turning=0.
//    - ori keeps its current value (a partial turn does not advance it); arrived is not pulsed.
//    - abort in the same cycle as a tgt_valid&&tgt_ready accept: the accept wins.
//  NAV_ABORT_EN not defined: no abort port; a target always runs to DONE or to reset.
// STRUCTURE
//  Package nav_pkg holds:
//    - ORI_PY/ORI_PX/ORI_NX/ORI_NY localparams and MOT_STOP/MOT_FWD/MOT_REV codes.
//    - state encoding (IDLE, ALIGN, TURN, DRIVE, DONE).
//    - functions ori_cw(ori) and ori_ccw(ori).
//  Sub-module nav_turn_timer (start, done pulse, TURN_CYCLES param) holds the turn counter.
// TESTING
//  1. Reset; cur=(0,38), ori=00; target (0,40) -> no TURN, motors 01/01 until cur_y=40;
//     arrived pulses once; ori stays 00.
//  2. cur=(0,38), ori=00; target (5,38) -> one CW turn of exactly TURN_CYCLES cycles with
//     turning=1; ori=01; DRIVE until cur_x=5; arrived.
//  3. cur=(3,38), ori=00; target (3,30) -> two CW turns, ori 00->01->11; DRIVE; arrived at
//     cur_y=30.
//  4. target = current position -> arrived exactly 2 cycles after accept, motors never leave 00.
//  5. Assert tgt_valid with a new target mid-DRIVE -> tgt_ready=0, target unchanged, original
//     arrives.
//  6. Assert rst at half TURN -> next cycle IDLE, ori=00, turning=0.
//     NAV_ABORT_EN build: abort mid-DRIVE -> IDLE, no arrived pulse.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared heading/motor codes, FSM state encoding and heading rotation helpers
// for the waypoint navigator.
package nav_pkg;

   localparam logic [1:0] ORI_PY = 2'b00;
   localparam logic [1:0] ORI_PX = 2'b01;
   localparam logic [1:0] ORI_NX = 2'b10;
   localparam logic [1:0] ORI_NY = 2'b11;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_FWD  = 2'b01;
   localparam logic [1:0] MOT_REV  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_TURN,
      ST_DRIVE,
      ST_DONE
   } nav_state_e;

   // Clockwise ring: +Y -> +X -> -Y -> -X -> +Y
   function automatic logic [1:0] ori_cw(input logic [1:0] o);
      case (o)
         ORI_PY:  return ORI_PX;
         ORI_PX:  return ORI_NY;
         ORI_NY:  return ORI_NX;
         default: return ORI_PY;
      endcase
   endfunction

   function automatic logic [1:0] ori_ccw(input logic [1:0] o);
      case (o)
         ORI_PY:  return ORI_NX;
         ORI_NX:  return ORI_NY;
         ORI_NY:  return ORI_PX;
         default: return ORI_PY;
      endcase
   endfunction

endpackage

// File: rtl/waypoint_navigator_if.sv
// Target handshake bundle: a producer offers (tgt_x, tgt_y) with tgt_valid,
// the navigator accepts when tgt_ready is high.
interface waypoint_navigator_if #(
   parameter int COORD_W = 33
);
   logic               tgt_valid;
   logic               tgt_ready;
   logic [COORD_W-1:0] tgt_x;
   logic [COORD_W-1:0] tgt_y;

   modport master (
      output tgt_valid,
      output tgt_x,
      output tgt_y,
      input  tgt_ready
   );

   modport slave (
      input  tgt_valid,
      input  tgt_x,
      input  tgt_y,
      output tgt_ready
   );
endinterface

// File: rtl/nav_turn_timer.sv
// Down-counter timing one in-place 90-degree turn; done is high on the last
// of TURN_CYCLES cycles following a start pulse.
module nav_turn_timer #(
   parameter int TURN_CYCLES = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clr,
   output logic done
);
   localparam int CNT_W = $clog2(TURN_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic             run;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         cnt <= CNT_W'(TURN_CYCLES - 1);
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) begin
            run <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign done = run && (cnt == '0);

endmodule

// File: rtl/waypoint_navigator.sv
// Waypoint navigator: closes the Y axis first, then X, turning in place in
// 90-degree steps. Optional NAV_ABORT_EN adds an abort input.
//
// state | meaning
// IDLE  | waiting for a target, tgt_ready high
// ALIGN | pick heading for the remaining axis, or finish
// TURN  | rotating in place one 90-degree step
// DRIVE | moving forward along the current heading
// DONE  | one-cycle arrived pulse, then back to IDLE
module waypoint_navigator
   import nav_pkg::*;
#(
   parameter int COORD_W     = 33,
   parameter int TURN_CYCLES = 5000
) (
   input  logic                clk,
   input  logic                rst,
   waypoint_navigator_if.slave tgt,
   input  logic [COORD_W-1:0]  cur_x,
   input  logic [COORD_W-1:0]  cur_y,
`ifdef NAV_ABORT_EN
   input  logic                abort,
`endif
   output logic [1:0]          ori,
   output logic                turning,
   output logic [1:0]          motor_l,
   output logic [1:0]          motor_r,
   output logic                busy,
   output logic                arrived
);

   nav_state_e         state, state_n;
   logic [COORD_W-1:0] tgt_xq, tgt_yq;
   logic               turn_cw, turn_cw_n;
   logic [1:0]         desired;
   logic [1:0]         ori_n, motor_l_n, motor_r_n;
   logic               turning_n, busy_n, arrived_n;
   logic               at_tgt, short_of_tgt;
   logic               abort_hit, turn_start, turn_done;

`ifdef NAV_ABORT_EN
   assign abort_hit = abort && (state != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign tgt.tgt_ready = (state == ST_IDLE) && !rst;
   assign at_tgt        = (cur_x == tgt_xq) && (cur_y == tgt_yq);
   assign turn_start    = (state_n == ST_TURN) && (state != ST_TURN);

   nav_turn_timer #(
      .TURN_CYCLES (TURN_CYCLES)
   ) u_turn_timer (
      .clk   (clk),
      .rst   (rst),
      .start (turn_start),
      .clr   (abort_hit),
      .done  (turn_done)
   );

   always_comb begin
      if (cur_y != tgt_yq) begin
         desired = (tgt_yq > cur_y) ? ORI_PY : ORI_NY;
      end else begin
         desired = (tgt_xq > cur_x) ? ORI_PX : ORI_NX;
      end
   end

   // Still approaching along the current heading; equal or overshot stops the drive.
   always_comb begin
      case (ori)
         ORI_PY:  short_of_tgt = cur_y < tgt_yq;
         ORI_NY:  short_of_tgt = cur_y > tgt_yq;
         ORI_PX:  short_of_tgt = cur_x < tgt_xq;
         default: short_of_tgt = cur_x > tgt_xq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ori     <= ORI_PY;
         turn_cw <= 1'b0;
         turning <= 1'b0;
         motor_l <= MOT_STOP;
         motor_r <= MOT_STOP;
         busy    <= 1'b0;
         arrived <= 1'b0;
         tgt_xq  <= '0;
         tgt_yq  <= '0;
      end else begin
         state   <= state_n;
         ori     <= ori_n;
         turn_cw <= turn_cw_n;
         turning <= turning_n;
         motor_l <= motor_l_n;
         motor_r <= motor_r_n;
         busy    <= busy_n;
         arrived <= arrived_n;
         if (tgt.tgt_valid && tgt.tgt_ready) begin
            tgt_xq <= tgt.tgt_x;
            tgt_yq <= tgt.tgt_y;
         end
      end
   end

   always_comb begin
      state_n   = state;
      turn_cw_n = turn_cw;
      case (state)
         ST_IDLE:  if (tgt.tgt_valid) state_n = ST_ALIGN;
         ST_ALIGN: begin
            if (at_tgt) begin
               state_n = ST_DONE;
            end else if (desired == ori) begin
               state_n = ST_DRIVE;
            end else begin
               state_n   = ST_TURN;
               // Only a single counter-clockwise step uses CCW; 180 degrees goes CW.
               turn_cw_n = (desired != ori_ccw(ori));
            end
         end
         ST_TURN:  if (turn_done) state_n = ST_ALIGN;
         ST_DRIVE: if (!short_of_tgt) state_n = ST_ALIGN;
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (abort_hit) state_n = ST_IDLE;
   end

   always_comb begin
      ori_n     = ori;
      motor_l_n = MOT_STOP;
      motor_r_n = MOT_STOP;
      if ((state == ST_TURN) && turn_done && !abort_hit) begin
         ori_n = turn_cw ? ori_cw(ori) : ori_ccw(ori);
      end
      case (state_n)
         ST_TURN: begin
            motor_l_n = turn_cw_n ? MOT_FWD : MOT_REV;
            motor_r_n = turn_cw_n ? MOT_REV : MOT_FWD;
         end
         ST_DRIVE: begin
            motor_l_n = MOT_FWD;
            motor_r_n = MOT_FWD;
         end
         default: ;
      endcase
      turning_n = (state_n == ST_TURN);
      busy_n    = (state_n != ST_IDLE);
      arrived_n = (state_n == ST_DONE);
   end

endmodule

// File: tb/tb_waypoint_navigator.sv
// Bench for waypoint_navigator: procedural reference model checked every cycle,
// an encoder stand-in moving cur_x/cur_y, directed scenarios and random targets.
module tb_waypoint_navigator;
   import nav_pkg::*;

   localparam int CW     = 33;
   localparam int TC     = 7;
   localparam int BUDGET = 4000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] cur_x = '0;
   logic [CW-1:0] cur_y = '0;
   logic [1:0]    ori, motor_l, motor_r;
   logic          turning, busy, arrived;
`ifdef NAV_ABORT_EN
   logic          abort = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;
   bit noise_en    = 1'b0;
   bit coast_en    = 1'b0;

   always #5 clk = ~clk;

   waypoint_navigator_if #(.COORD_W(CW)) tgt ();

   waypoint_navigator #(
      .COORD_W     (CW),
      .TURN_CYCLES (TC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tgt     (tgt),
      .cur_x   (cur_x),
      .cur_y   (cur_y),
`ifdef NAV_ABORT_EN
      .abort   (abort),
`endif
      .ori     (ori),
      .turning (turning),
      .motor_l (motor_l),
      .motor_r (motor_r),
      .busy    (busy),
      .arrived (arrived)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [1:0] m_ori = 2'b00;
   logic [1:0] m_ml = 2'b00, m_mr = 2'b00;
   bit         m_busy = 1'b0, m_turning = 1'b0, m_arrived = 1'b0;

   // Headings in clockwise order around the ring.
   function automatic logic [1:0] ring(input int i);
      case (i % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int ring_pos(input logic [1:0] h);
      for (int i = 0; i < 4; i++) if (ring(i) == h) return i;
      return 0;
   endfunction

   function automatic logic [1:0] heading_to(input logic [CW-1:0] tx, input logic [CW-1:0] ty);
      if (cur_y != ty) return (ty > cur_y) ? 2'b00 : 2'b11;
      return (tx > cur_x) ? 2'b01 : 2'b10;
   endfunction

   function automatic bit ahead(input logic [1:0] h, input logic [CW-1:0] tx, input logic [CW-1:0] ty);
      case (h)
         2'b00:   return ty > cur_y;
         2'b11:   return ty < cur_y;
         2'b01:   return tx > cur_x;
         default: return tx < cur_x;
      endcase
   endfunction

   function automatic void go_idle();
      m_busy = 1'b0; m_turning = 1'b0; m_arrived = 1'b0; m_ml = 2'b00; m_mr = 2'b00;
   endfunction

   function automatic bit killed();
      if (rst) begin
         m_ori = 2'b00;
         go_idle();
         return 1'b1;
      end
`ifdef NAV_ABORT_EN
      if (abort) begin
         go_idle();
         return 1'b1;
      end
`endif
      return 1'b0;
   endfunction

   task automatic m_run(input logic [CW-1:0] tx, input logic [CW-1:0] ty);
      logic [1:0] d;
      int         steps;
      bit         cw;
      m_busy = 1'b1; m_turning = 1'b0; m_arrived = 1'b0; m_ml = 2'b00; m_mr = 2'b00;
      forever begin
         @(posedge clk);
         if (killed()) return;
         if (cur_x == tx && cur_y == ty) begin
            m_arrived = 1'b1;
            @(posedge clk);
            if (killed()) return;
            go_idle();
            return;
         end
         d = heading_to(tx, ty);
         if (d == m_ori) begin
            m_ml = MOT_FWD; m_mr = MOT_FWD;
            do begin
               @(posedge clk);
               if (killed()) return;
            end while (ahead(m_ori, tx, ty));
            m_ml = 2'b00; m_mr = 2'b00;
         end else begin
            steps = (ring_pos(d) - ring_pos(m_ori) + 4) % 4;
            cw = (steps != 3);
            m_turning = 1'b1;
            m_ml = cw ? MOT_FWD : MOT_REV;
            m_mr = cw ? MOT_REV : MOT_FWD;
            repeat (TC) begin
               @(posedge clk);
               if (killed()) return;
            end
            m_ori = ring(ring_pos(m_ori) + (cw ? 1 : 3));
            m_turning = 1'b0; m_ml = 2'b00; m_mr = 2'b00;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_ori = 2'b00;
            go_idle();
         end else if (tgt.tgt_valid) begin
            m_run(tgt.tgt_x, tgt.tgt_y);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ori", 64'(ori), 64'(m_ori));
         chk("turning", 64'(turning), 64'(m_turning));
         chk("motor_l", 64'(motor_l), 64'(m_ml));
         chk("motor_r", 64'(motor_r), 64'(m_mr));
         chk("busy", 64'(busy), 64'(m_busy));
         chk("arrived", 64'(arrived), 64'(m_arrived));
         chk("tgt_ready", 64'(tgt.tgt_ready), 64'(!m_busy && !rst));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycle();
      int step;
      @(posedge clk);
      #1;
      if (motor_l == MOT_FWD && motor_r == MOT_FWD && !turning) begin
         step = (coast_en && $urandom_range(15) == 0) ? 2 : int'($urandom_range(1));
         case (ori)
            2'b00:   cur_y = cur_y + CW'(step);
            2'b11:   cur_y = cur_y - CW'(step);
            2'b01:   cur_x = cur_x + CW'(step);
            default: cur_x = cur_x - CW'(step);
         endcase
      end
      if (noise_en) begin
         tgt.tgt_valid = busy && ($urandom_range(3) == 0);
         tgt.tgt_x = CW'({$urandom(), $urandom()});
         tgt.tgt_y = CW'({$urandom(), $urandom()});
      end
   endtask

   task automatic rst_dut();
      tgt.tgt_valid = 1'b0;
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   task automatic offer(input logic [CW-1:0] x, input logic [CW-1:0] y);
      tgt.tgt_x = x; tgt.tgt_y = y; tgt.tgt_valid = 1'b1;
      cycle();
      if (!noise_en) tgt.tgt_valid = 1'b0;
   endtask

   task automatic run_to(input logic [CW-1:0] x, input logic [CW-1:0] y, input bit inject,
                         output int lat, output int turns, output int moving,
                         output int arrivals, output int inj);
      int n;
      lat = -1; turns = 0; moving = 0; arrivals = 0; inj = 0;
      offer(x, y);
      n = 1;
      while (n < BUDGET) begin
         if (arrived) begin
            arrivals++;
            if (lat < 0) lat = n;
         end
         if (turning) turns++;
         if (motor_l != MOT_STOP || motor_r != MOT_STOP) moving++;
         if (!busy) break;
         if (inject && inj < 3 && motor_l == MOT_FWD && motor_r == MOT_FWD && !turning) begin
            tgt.tgt_x = CW'(50); tgt.tgt_y = CW'(50); tgt.tgt_valid = 1'b1;
            inj++;
            #1 chk("ready_mid_drive", 64'(tgt.tgt_ready), 64'(0));
         end else if (inject) begin
            tgt.tgt_valid = 1'b0;
         end
         cycle();
         n++;
      end
      chk("idle_within_budget", 64'(busy), 64'(0));
   endtask

   int lat, turns, moving, arrivals, inj;
   logic [CW-1:0] rx, ry;

   initial begin
      tgt.tgt_valid = 1'b0; tgt.tgt_x = '0; tgt.tgt_y = '0;
      cur_x = CW'(0); cur_y = CW'(38);
      cycle();
      chk_en = 1'b1;
      cycle();
      chk("rst_ori", 64'(ori), 64'(0));
      chk("rst_motors", 64'({motor_l, motor_r}), 64'(0));
      chk("rst_busy_arrived_turning", 64'({busy, arrived, turning}), 64'(0));
      chk("rst_ready_low", 64'(tgt.tgt_ready), 64'(0));
      rst = 1'b0;
      #1 chk("ready_after_rst", 64'(tgt.tgt_ready), 64'(1));

      // 1: straight ahead on +Y
      run_to(CW'(0), CW'(40), 1'b0, lat, turns, moving, arrivals, inj);
      chk("t1_arrivals", 64'(arrivals), 64'(1));
      chk("t1_turns", 64'(turns), 64'(0));
      chk("t1_ori", 64'(ori), 64'(0));
      chk("t1_y", 64'(cur_y), 64'(40));

      // 2: one CW turn then +X
      cur_x = CW'(0); cur_y = CW'(38);
      run_to(CW'(5), CW'(38), 1'b0, lat, turns, moving, arrivals, inj);
      chk("t2_turn_cycles", 64'(turns), 64'(TC));
      chk("t2_ori", 64'(ori), 64'(1));
      chk("t2_x", 64'(cur_x), 64'(5));
      chk("t2_arrivals", 64'(arrivals), 64'(1));

      // 3: 180 degrees as two CW turns then -Y
      rst_dut();
      cur_x = CW'(3); cur_y = CW'(38);
      run_to(CW'(3), CW'(30), 1'b0, lat, turns, moving, arrivals, inj);
      chk("t3_turn_cycles", 64'(turns), 64'(2 * TC));
      chk("t3_ori", 64'(ori), 64'(3));
      chk("t3_y", 64'(cur_y), 64'(30));

      // 4: target equals position
      run_to(cur_x, cur_y, 1'b0, lat, turns, moving, arrivals, inj);
      chk("t4_latency", 64'(lat), 64'(2));
      chk("t4_motor_cycles", 64'(moving), 64'(0));
      chk("t4_arrivals", 64'(arrivals), 64'(1));

      // 5: new target offered mid-drive is ignored
      rst_dut();
      cur_x = CW'(0); cur_y = CW'(20);
      run_to(CW'(0), CW'(30), 1'b1, lat, turns, moving, arrivals, inj);
      chk("t5_injected", 64'(inj), 64'(3));
      chk("t5_pos", 64'({cur_x, cur_y}), 64'({CW'(0), CW'(30)}));
      chk("t5_arrivals", 64'(arrivals), 64'(1));

      // 6: reset halfway through a turn
      rst_dut();
      cur_x = CW'(0); cur_y = CW'(20);
      offer(CW'(10), CW'(20));
      repeat (1 + TC / 2) cycle();
      chk("t6_turning_before_rst", 64'(turning), 64'(1));
      rst = 1'b1;
      cycle();
      chk("t6_ori", 64'(ori), 64'(0));
      chk("t6_turning", 64'(turning), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      cycle();

`ifdef NAV_ABORT_EN
      cur_x = CW'(0); cur_y = CW'(20);
      offer(CW'(0), CW'(40));
      repeat (3) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_motors", 64'({motor_l, motor_r}), 64'(0));
      arrivals = 0;
      repeat (5) begin
         cycle();
         if (arrived) arrivals++;
      end
      chk("abort_no_arrival", 64'(arrivals), 64'(0));
`endif

      // random targets with overshoot and ignored offers while busy
      noise_en = 1'b1;
      coast_en = 1'b1;
      cur_x = CW'(30); cur_y = CW'(30);
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(5) == 0) begin
            rx = cur_x; ry = cur_y;
         end else begin
            rx = CW'($urandom_range(60, 10));
            ry = CW'($urandom_range(60, 10));
         end
         run_to(rx, ry, 1'b0, lat, turns, moving, arrivals, inj);
         chk("rand_arrivals", 64'(arrivals), 64'(1));
         chk("rand_pos", 64'({cur_x, cur_y}), 64'({rx, ry}));
      end
      noise_en = 1'b0;
      tgt.tgt_valid = 1'b0;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
